// File: rtl/dmem_responder_if.sv
// Load/store port between the MIPS core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic [31:0] io_out;

    modport master (output req, we, addr, wdata, input ready, rdata, err, busy, io_out);
    modport slave  (input req, we, addr, wdata, output ready, rdata, err, busy, io_out);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with memory-mapped output register and cycle counter,
// answering one request at a time after WAIT wait states.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] IO_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF4;

    logic [1:0]    r_state;
    logic [3:0]    r_wcnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_io;
    logic [31:0]   r_cnt;
    logic [31:0]   r_mem [DEPTH];

    logic          w_resp;
    logic          w_misal;
    logic          w_is_io;
    logic          w_is_cnt;
    logic          w_is_ram;
    logic          w_fault;
    logic          w_commit;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd;

    // Decode works only from the latched request, never from live bus inputs.
    assign w_resp   = (r_state == ST_RESP);
    assign w_misal  = (r_addr[1:0] != 2'b00);
    assign w_is_io  = (r_addr == IO_ADDR);
    assign w_is_cnt = (r_addr == CNT_ADDR);
    assign w_is_ram = (r_addr[31:2] < 30'(DEPTH));
    assign w_fault  = w_misal | ~(w_is_io | w_is_cnt | w_is_ram);
    assign w_commit = w_resp & r_we & ~w_fault;
    assign w_idx    = r_addr[AW+1:2];

    always_comb begin
        w_rd = '0;
        if (w_is_io)
            w_rd = r_io;
        else if (w_is_cnt)
            w_rd = r_cnt;
        else if (w_is_ram)
            w_rd = r_mem[w_idx];
    end

    assign bus.ready  = w_resp;
    assign bus.err    = w_resp & w_fault;
    assign bus.rdata  = (w_resp & ~r_we & ~w_fault) ? w_rd : '0;
    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.io_out = r_io;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_io    <= '0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_wcnt  <= 4'(WAIT);
                        r_state <= (WAIT > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    r_wcnt <= r_wcnt - 4'd1;
                    if (r_wcnt <= 4'd1)
                        r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_commit && w_is_io)
                        r_io <= r_wdata;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset edge still blocks the pending store.
    always_ff @(posedge clk) begin
        if (reset && w_commit && w_is_ram)
            r_mem[w_idx] <= r_wdata;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MIPS core's load/store port. It accepts one word request at a time over a req/ready handshake and answers after a programmable number of wait states. It holds a word-addressed data RAM plus two memory-mapped I/O words: an output register and a free-running cycle counter. It is the memory-side end of the core's address / write-data / read-data / write-enable interface, with a stall-capable handshake for the multicycle and pipelined cores.

## Interface
Parameters:
- DEPTH, 64: data RAM size in 32-bit words; power of two, 2..1024.
- WAIT, 2: wait states between request acceptance and response; 0..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- ready  out  1  one-cycle response strobe.
- rdata  out  32  load data; valid only while ready=1, else 0.
- err  out  1  qualifies ready: access faulted.
- busy  out  1  1 whenever state != IDLE.
- io_out  out  32  memory-mapped output register.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1: latch we/addr/wdata and load the wait counter with WAIT.
  - Next state is WAIT if WAIT>0, else RESP.
  - req=0: stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on that edge.
- RESP: drive ready=1 for exactly one cycle, then return to IDLE unconditionally.
- req is ignored in WAIT and RESP; it is not queued. The requester must re-present a request after seeing ready.
- Address decode uses the latched address:
  - addr[1:0] != 0: misaligned; err=1, no write, rdata=0.
  - addr == 0xFFFF_FFF0: io_out. A load returns io_out; a store writes io_out.
  - addr == 0xFFFF_FFF4: cycle counter. A load returns the count; a store is ignored with err=0.
  - addr[31:2] < DEPTH: RAM word addr[31:2].
  - Any other address: err=1, no write, rdata=0.
- Stores commit on the rising edge that ends the RESP cycle. RAM and io_out are written only when err=0.
- Loads: rdata in RESP reflects contents before any store in that same cycle. Only one access is in flight, so there is no hazard.
- Cycle counter: 32-bit, increments every non-reset cycle and wraps 0xFFFF_FFFF -> 0. A load returns the value in the RESP cycle.

## Timing
- Reset (reset=0 on an edge), applied in any state including mid-transaction:
  - state to IDLE, counters to 0, io_out to 0.
  - Outputs: ready=0, err=0, busy=0, rdata=0.
  - Any pending store is discarded. RAM contents are not cleared.
- Latency: req accepted at the edge ending cycle 0 gives ready=1 in cycle WAIT+1.
  - WAIT=0: ready in cycle 1.
  - WAIT=2: ready in cycle 3.
- Throughput: at most one transaction per WAIT+2 cycles. A new req is accepted at the earliest in the cycle after ready.
- busy=1 from cycle 1 through the RESP cycle inclusive.
- err and rdata are registered/combinational from latched state only. They never depend on the current req/addr inputs.

## Test plan
- Reset/idle:
  - Stimulus: hold reset=0 for 3 cycles, release, no req.
  - Required: ready=err=busy=0, rdata=0, io_out=0; counter load later returns a non-zero value.
- Store then load, WAIT=2:
  - Stimulus: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010.
  - Required: ready in cycle 3 for each access; load rdata=0xDEADBEEF, err=0.
- MMIO:
  - Stimulus: store 0x0000_00A5 to 0xFFFF_FFF0, then load it back. Then store to 0xFFFF_FFF4.
  - Required: io_out=0x000000A5 the cycle after RESP and the load returns 0xA5. The 0xFFFF_FFF4 store gives err=0 and the counter is unaffected.
- Faults:
  - Stimulus: load 0x0000_0002; store 0x1 to byte address DEPTH*4.
  - Required: both give ready with err=1 and rdata=0. A subsequent load of word 0 is unchanged.
- Handshake edges:
  - Stimulus: hold req=1 continuously.
  - Required: accepts exactly one request per WAIT+2 cycles. With WAIT=0, ready pulses every 2nd cycle.
- Reset mid-operation:
  - Stimulus: store 0x12345678 to 0x4, assert reset during WAIT, then load 0x4.
  - Required: no ready pulse for the aborted store; the load returns the prior contents.
